booth_mul_sequencer: RTL and testbench
======================================

Name: booth_mul_sequencer

Overview:
- Upstream operand-issue and result-collection stage for the 8x8 Booth multiplier core. Operates on a single clock.
- Accepts signed operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues one pair at a time to the core using its start/ready handshake, captures the 16-bit product, and returns products in order over a valid/ready output stream.

Parameters:
- W, 8, operand width; product width is 2*W.
- DEPTH, 4, operand FIFO entries; must be a power of two, 2 or more.

Ports:
- clk  in  1  clock; all registers update on the falling edge, the same edge the multiplier core uses.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_a  in  W  signed multiplicand.
- in_b  in  W  signed multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_product  out  2W  signed product.
- mul_start  out  1  start pulse to core.
- mul_a  out  W  core a_in.
- mul_b  out  W  core b_in.
- mul_product  in  2W  core r_out.
- mul_ready  in  1  core ready (high when core is idle).

Behaviour:
- Reset (asynchronous, reset=0):
  - FIFO emptied, state=IDLE.
  - in_ready=0 while reset is held, 1 after release.
  - out_valid=0, out_product=0, mul_start=0, mul_a=0, mul_b=0.
- Input push: in_valid and in_ready at a falling edge. in_ready is !full; there is no pass-through when full.
- FSM states, one-hot: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
  - IDLE: FIFO non-empty and mul_ready=1 -> pop head into mul_a/mul_b registers, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mul_start=1 for exactly one cycle; mul_a/mul_b are stable this cycle and the next. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for mul_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: on mul_ready=1, capture mul_product into out_product, set out_valid=1, go to HOLD.
  - HOLD: on out_valid and out_ready, clear out_valid and go to IDLE. With back-pressure, hold out_product stable and issue nothing new.
- Ordering:
  - Strictly in order; at most one operation in flight.
  - FIFO push continues during any state.
- Simultaneous push and pop on the same edge: both take effect; occupancy unchanged.
- Pointers: log2(DEPTH)-bit, wrap at DEPTH. Full and empty come from a separate count register of width log2(DEPTH)+1.
- Product: two's complement, 2W bits, taken directly from the core; no rounding or saturation.
- Latency: core busy is 8 shifts plus up to 8 adds. Minimum end-to-end latency from push to out_valid is 3 + core cycles.
- Reset mid-operation:
  - The in-flight operation and all queued pairs are discarded; no partial product is emitted.
  - The core shares the same reset.

Optional Feature:
- Macro: BOOTH_SEQ_ZERO_BYPASS_EN.
- Defined: in IDLE, if the FIFO head has in_a==0 or in_b==0, pop it and go directly to HOLD with out_product=0 and out_valid=1. mul_start is not pulsed, and mul_ready is not required to be high.
- Undefined: all pairs go through the core.

Decomposition:
- Package booth_pkg:
  - W default.
  - One-hot state typedef/localparams: IDLE=5'b00001, ISSUE=5'b00010, WAIT_BUSY=5'b00100, WAIT_DONE=5'b01000, HOLD=5'b10000.
  - Product width function.
- Sub-module booth_op_fifo: parameterised 2W-wide synchronous FIFO with push, pop, full, empty, and head data outputs.
- The FSM and output register live in the top level.

Test Plan:
- Push (3,5) with out_ready=1 -> exactly one mul_start pulse with mul_a=3, mul_b=5; out_product=16'h000F; out_valid for 1 cycle.
- Push (-128,-128), then (-1,127) back-to-back -> 16'h4000 then 16'hFF81, in order; second mul_start only after first handshake completes.
- out_ready=0 for 20 cycles after product of (7,-2) -> out_valid held, out_product=16'hFFF2 stable, mul_start stays 0 despite queued pairs.
- DEPTH=4: push 5 pairs while core busy -> in_ready drops after 4th accepted (one already in core); simultaneous push/pop at full boundary keeps count correct.
- Assert reset during WAIT_DONE with 2 pairs queued -> out_valid=0, FIFO empty, no product emitted after release; next pushed (2,2) yields 16'h0004.
- BOOTH_SEQ_ZERO_BYPASS_EN: push (0,99) -> out_product=0 with no mul_start pulse. Without the macro -> mul_start pulses and out_product=0.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared width defaults, one-hot FSM states and product width helper
// for the Booth multiplier operand sequencer.
package booth_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    ISSUE     = 5'b00010,
    WAIT_BUSY = 5'b00100,
    WAIT_DONE = 5'b01000,
    HOLD      = 5'b10000
  } state_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: falling-edge synchronous FIFO holding packed operand pairs.
// Occupancy is tracked by a separate count register.
module booth_op_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: buffers operand pairs, issues them to the Booth core one
// at a time, returns products in order. Zero bypass: BOOTH_SEQ_ZERO_BYPASS_EN.
module booth_mul_sequencer
  import booth_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_product,
  input  logic           mul_ready
);

  localparam int PW = prod_w(W);

  state_t        state;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          go;
  logic [PW-1:0] head;
  logic [W-1:0]  head_a;
  logic [W-1:0]  head_b;

  assign head_a   = head[PW-1:W];
  assign head_b   = head[W-1:0];
  assign in_ready = reset & ~full;
  assign push     = in_valid & in_ready;

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
  logic head_zero;
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign go        = mul_ready | head_zero;
`else
  assign go        = mul_ready;
`endif

  assign pop = (state == IDLE) & ~empty & go;

  booth_op_fifo #(
    .DW   (PW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  ({in_a, in_b}),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_product <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      mul_start <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (pop) begin
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
            if (head_zero) begin
              out_product <= '0;
              out_valid   <= 1'b1;
              state       <= HOLD;
            end else begin
              mul_a     <= head_a;
              mul_b     <= head_b;
              mul_start <= 1'b1;
              state     <= ISSUE;
            end
`else
            mul_a     <= head_a;
            mul_b     <= head_b;
            mul_start <= 1'b1;
            state     <= ISSUE;
`endif
          end
        end
        (state == ISSUE): begin
          state <= WAIT_BUSY;
        end
        (state == WAIT_BUSY): begin
          if (!mul_ready) state <= WAIT_DONE;
        end
        (state == WAIT_DONE): begin
          if (mul_ready) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end
        end
        (state == HOLD): begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: directed + random checks of the operand sequencer
// against a behavioural core model and an in-order product queue.
`timescale 1ns/1ps
module tb_booth_mul_sequencer;

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        mul_ready;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int vcyc = 0;
  logic [15:0] last_out = '0;
  logic        took;

  logic [15:0] exp_q[$];
  logic [15:0] iss_q[$];

  logic       core_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] ca;
  logic [7:0] cb;

  always #5 clk = ~clk;

  booth_mul_sequencer #(.W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_product(mul_product),
    .mul_ready  (mul_ready)
  );

  function automatic logic [15:0] smul(input logic signed [7:0] a,
                                       input logic signed [7:0] b);
    logic signed [15:0] r;
    r = a * b;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural Booth core: busy 8..16 cycles after a start, then a*b.
  initial begin
    mul_ready   = 1'b1;
    mul_product = '0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        core_busy = 1'b0;
        mul_ready = 1'b1;
      end else if (core_busy) begin
        chk("start_while_busy", {31'd0, mul_start}, 32'd0);
        busy_cnt--;
        if (busy_cnt == 0) begin
          mul_product = smul(ca, cb);
          mul_ready   = 1'b1;
          core_busy   = 1'b0;
        end
      end else if (mul_start) begin
        starts++;
        chk("start_with_out_valid", {31'd0, out_valid}, 32'd0);
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", {31'd0, mul_start}, 32'd0);
        end else begin
          chk("issue_ab", {16'd0, mul_a, mul_b}, {16'd0, iss_q.pop_front()});
        end
        ca        = mul_a;
        cb        = mul_b;
        busy_cnt  = $urandom_range(8, 16);
        core_busy = 1'b1;
        mul_ready = 1'b0;
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic ordy);
    @(posedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    took      = v & in_ready;
    if (out_valid) vcyc++;
    if (out_valid && ordy) begin
      last_out = out_product;
      if (exp_q.size() == 0)
        chk("out_unexpected", {31'd0, out_valid}, 32'd0);
      else
        chk("out_product", {16'd0, out_product}, {16'd0, exp_q.pop_front()});
    end
    if (took) begin
      exp_q.push_back(smul(a, b));
      if (!(ZB && (a == 8'd0 || b == 8'd0))) iss_q.push_back({a, b});
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, ordy);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic ordy);
    int i;
    i = 0;
    do begin
      step(1'b1, a, b, ordy);
      i++;
    end while (!took && i < 300);
    if (!took) chk("push_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    do begin
      step(1'b0, 8'd0, 8'd0, 1'b1);
      i++;
    end while ((exp_q.size() != 0 || out_valid || core_busy) && i < 2000);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int s0;
    int v0;
    logic [7:0] pa[6];
    logic [7:0] pb[6];

    // Reset state
    repeat (3) @(posedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_product", {16'd0, out_product}, 32'd0);
    chk("rst_mul_start", {31'd0, mul_start}, 32'd0);
    chk("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single product (3,5)
    s0 = starts;
    v0 = vcyc;
    push(8'd3, 8'd5, 1'b1);
    drain();
    chk("t1_starts", starts - s0, 32'd1);
    chk("t1_mul_a", {24'd0, ca}, 32'd3);
    chk("t1_mul_b", {24'd0, cb}, 32'd5);
    chk("t1_product", {16'd0, last_out}, 32'h000F);
    chk("t1_valid_cycles", vcyc - v0, 32'd1);

    // Back-to-back extreme values
    s0 = starts;
    push(8'h80, 8'h80, 1'b1);
    push(8'hFF, 8'h7F, 1'b1);
    drain();
    chk("t2_starts", starts - s0, 32'd2);
    chk("t2_last", {16'd0, last_out}, 32'hFF81);

    // Back-pressure with queued pairs
    push(8'd7, 8'hFE, 1'b0);
    push(8'd1, 8'd2, 1'b0);
    push(8'd3, 8'd3, 1'b0);
    for (int i = 0; i < 300 && !out_valid; i++) idle(1, 1'b0);
    s0 = starts;
    for (int i = 0; i < 20; i++) begin
      idle(1, 1'b0);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_product", {16'd0, out_product}, 32'hFFF2);
    end
    chk("t3_no_start", starts - s0, 32'd0);
    drain();

    // Fill the FIFO while the core is busy
    for (int i = 0; i < 6; i++) begin
      pa[i] = 8'($urandom_range(1, 255));
      pb[i] = 8'($urandom_range(1, 255));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pa[i], pb[i], 1'b1);
      chk("t4_accept", {31'd0, took}, 32'd1);
    end
    step(1'b1, pa[5], pb[5], 1'b1);
    chk("t4_full_reject", {31'd0, took}, 32'd0);
    chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
    if (!took) push(pa[5], pb[5], 1'b1);
    push(8'd9, 8'd9, 1'b1);
    drain();
    chk("t4_last", {16'd0, last_out}, 32'h0051);

    // Reset while waiting on the core
    push(8'd5, 8'd6, 1'b1);
    push(8'd2, 8'd3, 1'b1);
    push(8'd4, 8'd4, 1'b1);
    for (int i = 0; i < 100 && !core_busy; i++) idle(1, 1'b1);
    idle(3, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_mul_start", {31'd0, mul_start}, 32'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    iss_q.delete();
    @(posedge clk);
    reset = 1'b1;
    s0 = starts;
    v0 = vcyc;
    idle(40, 1'b1);
    chk("t5_no_output", vcyc - v0, 32'd0);
    chk("t5_no_issue", starts - s0, 32'd0);
    push(8'd2, 8'd2, 1'b1);
    drain();
    chk("t5_product", {16'd0, last_out}, 32'h0004);

    // Zero operand
    s0 = starts;
    last_out = 16'hFFFF;
    push(8'd0, 8'd99, 1'b1);
    drain();
    chk("t6_starts", starts - s0, ZB ? 32'd0 : 32'd1);
    chk("t6_product", {16'd0, last_out}, 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'd0;
      step(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 3) != 0));
    end
    drain();
    chk("final_exp_empty", exp_q.size(), 32'd0);
    chk("final_iss_empty", iss_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
